// File: rtl/des_decrypt_key_sched.sv
// DES decryption key scheduler: emits K16..K1 over valid/ready by right-rotating the PC-1 halves.
// Optional key parity check is enabled by defining DES_KEY_PARITY_CHK_EN.
module des_decrypt_key_sched (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] key_in,
  input  logic        start,
  output logic [47:0] subkey,
  output logic [4:0]  key_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy,
  output logic        done
`ifdef DES_KEY_PARITY_CHK_EN
  ,
  output logic        parity_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // FIPS 46-3 tables, 1-based bit numbers with bit 1 as the MSB
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'd0;
    for (int j = 0; j < 48; j++) begin
      r[6'(47 - j)] = cd[6'(56 - PC2_TBL[j])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotr1(input logic [27:0] x);
    return {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rotr2(input logic [27:0] x);
    return {x[1:0], x[27:2]};
  endfunction

`ifdef DES_KEY_PARITY_CHK_EN
  // True when any byte has even parity; DES keys need odd parity in every byte
  function automatic logic key_parity_bad(input logic [63:0] k);
    logic [63:0] t;
    logic        bad;
    t   = k;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if ((^t[7:0]) == 1'b0) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
      t = {8'h00, t[63:8]};
    end
    return bad;
  endfunction
`else
  logic unused_key_parity_bits;
  assign unused_key_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                    key_in[24], key_in[16], key_in[8],  key_in[0]};
`endif

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [4:0]  step_q, step_d;
  logic [4:0]  step_inc;
  logic        accept;
`ifdef DES_KEY_PARITY_CHK_EN
  logic        parity_err_q, parity_err_d;
`endif

  assign accept   = (state_q == ST_RUN) && subkey_ready;
  assign step_inc = step_q + 5'd1;

  // State and key-half registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      c_q          <= 28'd0;
      d_q          <= 28'd0;
      step_q       <= 5'd0;
`ifdef DES_KEY_PARITY_CHK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      d_q          <= d_d;
      step_q       <= step_d;
`ifdef DES_KEY_PARITY_CHK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept && (step_q == 5'd16)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Key-half datapath; C16 equals C0, so right rotation walks the schedule backwards
  always_comb begin
    c_d    = c_q;
    d_d    = d_q;
    step_d = step_q;
`ifdef DES_KEY_PARITY_CHK_EN
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          {c_d, d_d} = pc1(key_in);
          step_d     = 5'd1;
`ifdef DES_KEY_PARITY_CHK_EN
          parity_err_d = key_parity_bad(key_in);
`endif
        end else begin
          step_d = step_q;
        end
      end
      ST_RUN: begin
        if (accept && (step_q != 5'd16)) begin
          step_d = step_inc;
          if ((step_inc == 5'd2) || (step_inc == 5'd9) || (step_inc == 5'd16)) begin
            c_d = rotr1(c_q);
            d_d = rotr1(d_q);
          end else begin
            c_d = rotr2(c_q);
            d_d = rotr2(d_q);
          end
        end else begin
          step_d = step_q;
        end
      end
      default: begin
        step_d = step_q;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    subkey_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_RUN: begin
        subkey_valid = 1'b1;
        busy         = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    if (subkey_valid) begin
      subkey  = pc2({c_q, d_q});
      key_idx = 5'd17 - step_q;
    end else begin
      subkey  = 48'd0;
      key_idx = 5'd0;
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Self-checking bench for des_decrypt_key_sched against a forward FIPS 46-3 key schedule model.
module tb_des_decrypt_key_sched;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [63:0] key_in;
  logic        start;
  logic [47:0] subkey;
  logic [4:0]  key_idx;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        busy;
  logic        done;
`ifdef DES_KEY_PARITY_CHK_EN
  logic        parity_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] exp_k [1:16];

  localparam logic [63:0] GOLDEN = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_decrypt_key_sched dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_in       (key_in),
    .start        (start),
    .subkey       (subkey),
    .key_idx      (key_idx),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .busy         (busy),
    .done         (done)
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // Forward schedule: left shifts in round order, storing K1..K16
  task automatic compute_sched(input logic [63:0] key);
    logic        kb [1:64];
    logic        c  [1:28];
    logic        d  [1:28];
    logic        t;
    logic [47:0] k;
    int          p;
    for (int i = 1; i <= 64; i++) kb[i] = key[64 - i];
    for (int i = 1; i <= 28; i++) begin
      c[i] = kb[PC1_T[i - 1]];
      d[i] = kb[PC1_T[i + 27]];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < SHIFT_T[r - 1]; s++) begin
        t = c[1];
        for (int i = 1; i < 28; i++) c[i] = c[i + 1];
        c[28] = t;
        t = d[1];
        for (int i = 1; i < 28; i++) d[i] = d[i + 1];
        d[28] = t;
      end
      for (int j = 1; j <= 48; j++) begin
        p = PC2_T[j - 1];
        k[48 - j] = (p <= 28) ? c[p] : d[p - 28];
      end
      exp_k[r] = k;
    end
  endtask

  function automatic logic parity_model(input logic [63:0] key);
    logic bad;
    int   ones;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(key[b * 8 + i]);
      if (ones % 2 == 0) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [63:0] key);
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; subkey_ready = 1'b0; key_in = 64'd0;
    repeat (2) tick();
    n_cmp++;
    if ({subkey, key_idx, subkey_valid, busy, done} !== 56'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got subkey=%h idx=%0d v=%b busy=%b done=%b, expected all zero",
               subkey, key_idx, subkey_valid, busy, done);
    end
`ifdef DES_KEY_PARITY_CHK_EN
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_parity: got %b expected 0", parity_err);
    end
`endif
    n_rst = 1'b1;
    tick();
    n_cmp++;
    if ({subkey_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: got v=%b busy=%b done=%b expected 000", subkey_valid, busy, done);
    end
  endtask

  task automatic test_golden;
    compute_sched(GOLDEN);
    subkey_ready = 1'b1;
    pulse_start(GOLDEN);
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if (subkey_valid !== 1'b1 || busy !== 1'b1 || key_idx !== 5'(17 - c) || subkey !== exp_k[17 - c]) begin
        n_err++;
        $display("FAIL golden_cycle%0d: got v=%b busy=%b idx=%0d subkey=%h expected v=1 busy=1 idx=%0d subkey=%h",
                 c, subkey_valid, busy, key_idx, subkey, 17 - c, exp_k[17 - c]);
      end
      if (c == 1 || c == 15 || c == 16) begin
        n_cmp++;
        if ((c == 1  && subkey !== 48'hCB3D8B0E17F5) ||
            (c == 15 && subkey !== 48'h79AED9DBC9E5) ||
            (c == 16 && subkey !== 48'h1B02EFFC7072)) begin
          n_err++;
          $display("FAIL golden_const_cycle%0d: got subkey=%h", c, subkey);
        end
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b1 || subkey !== 48'd0 || key_idx !== 5'd0) begin
      n_err++;
      $display("FAIL golden_done: got done=%b v=%b busy=%b subkey=%h idx=%0d expected done=1 v=0 busy=1 zeros",
               done, subkey_valid, busy, subkey, key_idx);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL golden_back_idle: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure;
    int hs = 0, dones = 0, stalls = 0, exp_idx = 16;
    compute_sched(GOLDEN);
    subkey_ready = 1'b1;
    pulse_start(GOLDEN);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done === 1'b1) dones++;
      if (subkey_valid === 1'b1) begin
        n_cmp++;
        if (exp_idx < 1 || key_idx !== 5'(exp_idx) || subkey !== exp_k[exp_idx]) begin
          n_err++;
          $display("FAIL backpressure_key: got idx=%0d subkey=%h expected idx=%0d", key_idx, subkey, exp_idx);
        end
        if (exp_idx == 9 && stalls < 5) begin
          subkey_ready = 1'b0;
          stalls++;
        end else begin
          subkey_ready = 1'b1;
          hs++;
          exp_idx--;
        end
      end
      tick();
    end
    subkey_ready = 1'b1;
    n_cmp++;
    if (hs !== 16 || dones !== 1 || stalls !== 5) begin
      n_err++;
      $display("FAIL backpressure_totals: got hs=%0d dones=%0d stalls=%0d expected 16 1 5", hs, dones, stalls);
    end
  endtask

  task automatic test_start_while_busy;
    compute_sched(GOLDEN);
    subkey_ready = 1'b1;
    pulse_start(GOLDEN);
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if (subkey_valid !== 1'b1 || key_idx !== 5'(17 - c) || subkey !== exp_k[17 - c]) begin
        n_err++;
        $display("FAIL busy_start_cycle%0d: got v=%b idx=%0d subkey=%h expected idx=%0d subkey=%h",
                 c, subkey_valid, key_idx, subkey, 17 - c, exp_k[17 - c]);
      end
      start  = (c == 3 || c == 16);
      key_in = start ? 64'hFFFFFFFFFFFFFFFF : GOLDEN;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || subkey_valid !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_after: got busy=%b v=%b expected 0 0", busy, subkey_valid);
    end
  endtask

  task automatic test_reset_mid;
    int found = 0;
    int dones = 0;
    compute_sched(GOLDEN);
    subkey_ready = 1'b1;
    pulse_start(GOLDEN);
    for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
      if (subkey_valid === 1'b1 && key_idx === 5'd7) found = 1;
      else tick();
    end
    n_cmp++;
    if (found == 0) begin
      n_err++;
      $display("FAIL reset_mid_reach7: got idx=%0d expected to reach 7", key_idx);
    end
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({subkey, key_idx, subkey_valid, busy, done} !== 56'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got subkey=%h idx=%0d v=%b busy=%b done=%b expected zeros",
               subkey, key_idx, subkey_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_rst = 1'b1;
    tick();
    if (done === 1'b1) dones++;
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
    end
    pulse_start(GOLDEN);
    n_cmp++;
    if (subkey_valid !== 1'b1 || key_idx !== 5'd16 || subkey !== 48'hCB3D8B0E17F5) begin
      n_err++;
      $display("FAIL reset_mid_restart: got v=%b idx=%0d subkey=%h expected 1 16 cb3d8b0e17f5",
               subkey_valid, key_idx, subkey);
    end
    repeat (18) tick();
  endtask

  task automatic test_random;
    logic [63:0] key;
    int hs, dones, exp_idx;
    for (int n = 0; n < 5; n++) begin
      key = {$urandom, $urandom};
      compute_sched(key);
      hs = 0; dones = 0; exp_idx = 16;
      pulse_start(key);
`ifdef DES_KEY_PARITY_CHK_EN
      n_cmp++;
      if (parity_err !== parity_model(key)) begin
        n_err++;
        $display("FAIL random_parity: key=%h got %b expected %b", key, parity_err, parity_model(key));
      end
`endif
      for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
        subkey_ready = 1'($urandom_range(0, 1));
        if (done === 1'b1) dones++;
        if (subkey_valid === 1'b1) begin
          n_cmp++;
          if (exp_idx < 1 || key_idx !== 5'(exp_idx) || subkey !== exp_k[exp_idx]) begin
            n_err++;
            $display("FAIL random_key: key=%h got idx=%0d subkey=%h expected idx=%0d", key, key_idx, subkey, exp_idx);
          end
          if (subkey_ready) begin
            hs++;
            exp_idx--;
          end
        end
        if (dones == 0) tick();
      end
      n_cmp++;
      if (hs != 16 || dones != 1) begin
        n_err++;
        $display("FAIL random_totals: key=%h got hs=%0d dones=%0d expected 16 1", key, hs, dones);
      end
      tick();
    end
    subkey_ready = 1'b1;
  endtask

`ifdef DES_KEY_PARITY_CHK_EN
  task automatic test_parity;
    int bad = 0;
    subkey_ready = 1'b1;
    pulse_start(GOLDEN);
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_golden: got %b expected 0", parity_err);
    end
    repeat (17) tick();
    pulse_start(64'd0);
    for (int c = 0; c < 17; c++) begin
      if (parity_err !== 1'b1) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0 || parity_err !== 1'b1) begin
      n_err++;
      $display("FAIL parity_zero_held: got %0d low cycles, now %b expected 1 throughout", bad, parity_err);
    end
    pulse_start(GOLDEN);
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clear: got %b expected 0", parity_err);
    end
    repeat (18) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_golden();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_random();
`ifdef DES_KEY_PARITY_CHK_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
